// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - shared types and helpers for the elevator car controller
package elevador_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        LLEGADA  = 2'd3
    } estado_t;

    localparam int N_FLOORS_DEF = 4;
    localparam int MAX_FLOORS   = 32;

    // Exactly one bit set; callers zero-extend their floor vector to MAX_FLOORS.
    function automatic logic onehot_valid(input logic [MAX_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - MAX_FLOORS'(1))) == '0);
    endfunction

endpackage

// File: rtl/elevador_onehot_cmp.sv
// rtl/elevador_onehot_cmp.sv - magnitude compare of two one-hot floor vectors
module elevador_onehot_cmp #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         mayor,
    output logic         menor,
    output logic         igual
);

    // For one-hot codes a higher set bit is a higher floor, so plain unsigned compare works.
    assign mayor = (a > b);
    assign menor = (a < b);
    assign igual = (a == b);

endmodule

// File: rtl/elevador_cabina.sv
// rtl/elevador_cabina.sv - car drive model: moves one floor per TRAVEL_CYCLES and reports arrival
module elevador_cabina
    import elevador_pkg::*;
#(
    parameter int N_FLOORS      = N_FLOORS_DEF,
    parameter int TRAVEL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] siguiente,
    input  logic                mover,
    input  logic                puerta,
    output logic [N_FLOORS-1:0] piso_actual,
    output logic                llego,
    output logic                motor_sube,
    output logic                motor_baja,
    output logic [1:0]          estado_cab,
    output logic                error_cmd
);

    localparam int CW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TRAVEL_CYCLES - 1);

    estado_t             estado;
    logic [N_FLOORS-1:0] objetivo;
    logic [CW-1:0]       cnt;
    logic [N_FLOORS-1:0] paso;
    logic                mayor, menor, igual;
    logic                cmd_ok;

    elevador_onehot_cmp #(.N(N_FLOORS)) u_cmp (
        .a     (siguiente),
        .b     (piso_actual),
        .mayor (mayor),
        .menor (menor),
        .igual (igual)
    );

    assign cmd_ok     = onehot_valid(MAX_FLOORS'(siguiente));
    assign estado_cab = estado;

    // Next floor position in the current travel direction.
    always_comb begin
        paso = piso_actual;
        if (estado == SUBIENDO)
            paso = {piso_actual[N_FLOORS-2:0], 1'b0};
        else if (estado == BAJANDO)
            paso = {1'b0, piso_actual[N_FLOORS-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado      <= PARADO;
            piso_actual <= N_FLOORS'(1);
            objetivo    <= N_FLOORS'(1);
            cnt         <= '0;
            llego       <= 1'b0;
            motor_sube  <= 1'b0;
            motor_baja  <= 1'b0;
            error_cmd   <= 1'b0;
        end else begin
            case (estado)
                PARADO: begin
                    if (mover && !puerta) begin
                        if (!cmd_ok) begin
                            error_cmd <= 1'b1;
                        end else begin
                            error_cmd <= 1'b0;
                            objetivo  <= siguiente;
                            if (mayor) begin
                                estado     <= SUBIENDO;
                                motor_sube <= 1'b1;
                            end else if (menor) begin
                                estado     <= BAJANDO;
                                motor_baja <= 1'b1;
                            end else if (igual) begin
                                estado <= LLEGADA;
                                llego  <= 1'b1;
                            end
                        end
                    end
                end
                SUBIENDO, BAJANDO: begin
                    // An open door stalls the car: motor off, count frozen, state kept.
                    if (puerta) begin
                        motor_sube <= 1'b0;
                        motor_baja <= 1'b0;
                    end else begin
                        motor_sube <= (estado == SUBIENDO);
                        motor_baja <= (estado == BAJANDO);
                        if (cnt == CNT_LAST) begin
                            cnt         <= '0;
                            piso_actual <= paso;
                            if (paso == objetivo) begin
                                estado     <= LLEGADA;
                                llego      <= 1'b1;
                                motor_sube <= 1'b0;
                                motor_baja <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LLEGADA: begin
                    if (!mover) begin
                        estado <= PARADO;
                        llego  <= 1'b0;
                    end
                end
                default: estado <= PARADO;
            endcase
        end
    end

endmodule

// File: tb/tb_elevador_cabina.sv
// tb/tb_elevador_cabina.sv - randomized scoreboard bench for elevador_cabina
module tb_elevador_cabina;

    localparam int NF = 4;
    localparam int TC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NF-1:0] siguiente = '0;
    logic          mover = 1'b0;
    logic          puerta = 1'b0;
    logic [NF-1:0] piso_actual;
    logic          llego, motor_sube, motor_baja, error_cmd;
    logic [1:0]    estado_cab;

    elevador_cabina #(.N_FLOORS(NF), .TRAVEL_CYCLES(TC)) dut (
        .clk         (clk),
        .rst         (rst),
        .siguiente   (siguiente),
        .mover       (mover),
        .puerta      (puerta),
        .piso_actual (piso_actual),
        .llego       (llego),
        .motor_sube  (motor_sube),
        .motor_baja  (motor_baja),
        .estado_cab  (estado_cab),
        .error_cmd   (error_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int floor;
        int arrive;
        int up_cyc;
        int dn_cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   model_floor = 0;
    bit   mon_en = 1'b0;
    bit   prev_llego = 1'b0;
    bit   prev_err = 1'b0;
    int   up_cnt = 0;
    int   dn_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: response = llego rising (arrival) or error_cmd rising (rejected command).
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("piso_onehot", $countones(piso_actual), 1);
            check("motors_exclusive", int'(motor_sube & motor_baja), 0);
            up_cnt += int'(motor_sube);
            dn_cnt += int'(motor_baja);
            if ((llego && !prev_llego) || (error_cmd && !prev_err)) begin
                if (q.size() == 0) begin
                    check("unexpected_response", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("resp_kind_err", int'(error_cmd), int'(e.is_err));
                    check("resp_kind_llego", int'(llego), int'(!e.is_err));
                    check("resp_time", cyc, e.arrive);
                    check("resp_piso", int'(piso_actual), 1 << e.floor);
                    check("resp_up_cycles", up_cnt, e.up_cyc);
                    check("resp_dn_cycles", dn_cnt, e.dn_cyc);
                    if (!e.is_err) check("resp_estado", int'(estado_cab), 3);
                end
                up_cnt = 0;
                dn_cnt = 0;
            end
            prev_llego = llego;
            prev_err   = error_cmd;
        end
    end

    // Issue one command. tgt_vec may be invalid; pre = cycles of door held open before departure.
    task automatic issue(input logic [NF-1:0] tgt_vec, input int pre, input int stall);
        exp_t e;
        int   t, k, n;
        bit   valid;
        valid = ($countones(tgt_vec) == 1);
        siguiente = tgt_vec;
        mover     = 1'b1;
        puerta    = (pre > 0);
        for (int i = 0; i < pre; i++) begin
            @(posedge clk); #1;
        end
        puerta = 1'b0;
        if (!valid) begin
            e = '{1'b1, model_floor, cyc + 1, 0, 0};
            q.push_back(e);
            @(posedge clk); #1;
            mover = 1'b0;
            @(posedge clk); #1;
            return;
        end
        t = $clog2(tgt_vec);
        k = (t > model_floor) ? t - model_floor : model_floor - t;
        if (k == 0) stall = 0;
        e = '{1'b0, t, cyc + 1 + k * TC + stall,
              (t > model_floor) ? k * TC : 0, (t < model_floor) ? k * TC : 0};
        q.push_back(e);
        model_floor = t;
        @(posedge clk); #1;
        if (stall > 0) begin
            siguiente = NF'($urandom);
            @(posedge clk); #1;
            puerta = 1'b1;
            for (int i = 0; i < stall; i++) begin
                siguiente = NF'($urandom);
                @(posedge clk); #1;
            end
            puerta = 1'b0;
        end
        n = 0;
        while (!llego && n < 200) begin
            siguiente = NF'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (!llego) begin
            check("llego_timeout", 0, 1);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "FAIL llego_timeout");
        end
        mover = 1'b0;
        @(posedge clk); #1;
        check("back_to_parado", int'(estado_cab), 0);
        check("llego_dropped", int'(llego), 0);
    endtask

    initial begin
        logic [NF-1:0] v;
        int            f;
        #23;
        check("rst_piso", int'(piso_actual), 1);
        check("rst_llego", int'(llego), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("init_piso", int'(piso_actual), 1);
        check("init_llego", int'(llego), 0);
        check("init_motors", int'({motor_sube, motor_baja}), 0);
        check("init_estado", int'(estado_cab), 0);
        check("init_error", int'(error_cmd), 0);
        mon_en = 1'b1;

        issue(4'b0100, 0, 0);
        issue(4'b0001, 0, 0);
        issue(4'b0010, 0, 3);
        issue(4'b0000, 0, 0);
        issue(4'b0010, 0, 0);
        issue(4'b0110, 2, 0);
        issue(4'b0010, 1, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do v = NF'($urandom); while ($countones(v) == 1);
                issue(v, $urandom_range(0, 2), 0);
                f = (model_floor + 1) % NF;
                issue(NF'(1 << f), 0, $urandom_range(0, 3));
            end else begin
                f = $urandom_range(0, NF - 1);
                issue(NF'(1 << f), $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        issue(4'b0010, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        mon_en = 1'b0;
        siguiente = 4'b1000;
        mover = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midtravel_moving", int'(motor_sube), 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_piso", int'(piso_actual), 1);
        check("arst_motors", int'({motor_sube, motor_baja}), 0);
        check("arst_llego", int'(llego), 0);
        check("arst_estado", int'(estado_cab), 0);
        mover = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevador_cabina.md
Name: elevador_cabina

Overview:
- Car-side drive model and controller for the elevator: the responder to the floor FSM.
- Accepts the one-hot target floor (`siguiente`) plus a go command (`mover`) from the floor FSM.
- Drives the motor up or down one floor per TRAVEL_CYCLES clocks, tracks the current floor and returns `llego` (arrived) to the FSM.
- Sits between the floor FSM and the physical car/motor interface; also serves as a closed-loop bench partner for the FSM.

Parameters:
- N_FLOORS, 4: number of floors; width of every one-hot floor vector.
- TRAVEL_CYCLES, 4: clocks to travel one floor. Must be ≥ 1; counter width is clog2(TRAVEL_CYCLES), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets; release is synchronous to clk by the system).
- siguiente  in  N_FLOORS  one-hot target floor from the floor FSM.
- mover  in  1  go command; level, held by the FSM until it has seen llego.
- puerta  in  1  door open; 1 inhibits all motion.
- piso_actual  out  N_FLOORS  one-hot current floor.
- llego  out  1  car is at the latched target; level.
- motor_sube  out  1  motor driving up.
- motor_baja  out  1  motor driving down.
- estado_cab  out  2  current state encoding.
- error_cmd  out  1  last command had an invalid target.

Behaviour:
- Reset (rst=0, asynchronous): state PARADO, piso_actual = one-hot bit0 (ground), target register = bit0, counter = 0, all other outputs 0.
- States and encoding: PARADO=0, SUBIENDO=1, BAJANDO=2, LLEGADA=3. All outputs are registered.
- PARADO:
  - Evaluated only when mover=1 and puerta=0.
  - If siguiente is not exactly one-hot (zero or multi-hot): set error_cmd=1 and stay in PARADO.
  - Otherwise latch siguiente into the target register, clear error_cmd, then:
    - target above current: go to SUBIENDO.
    - target below current: go to BAJANDO.
    - target equal to current: go to LLEGADA.
- SUBIENDO / BAJANDO:
  - motor_sube (respectively motor_baja) = 1 in the same cycle the state is entered, i.e. 1 clock after mover is sampled.
  - The counter increments each clock.
  - When the counter reaches TRAVEL_CYCLES-1: clear it and shift piso_actual one position up (left) or down (right).
  - If the shifted value equals the target, go to LLEGADA on that same edge.
  - Changes to siguiente during travel are ignored; the target was latched at departure.
  - mover dropping during travel is ignored; the travel completes.
  - puerta=1 during travel:
    - Counter freezes and motor_sube/motor_baja drop to 0 in the next registered cycle.
    - State is held.
    - When puerta returns to 0, the count resumes from the frozen value.
- Travel time: k floors takes k*TRAVEL_CYCLES clocks in SUBIENDO/BAJANDO (no door stall). llego rises on the edge where the final shift occurs.
- LLEGADA:
  - llego=1 and both motor outputs 0.
  - Stay while mover=1.
  - When mover=0: go to PARADO with llego=0 on the next edge.
- Boundaries:
  - piso_actual never shifts past bit N_FLOORS-1 or bit0; this is guaranteed because the target is valid and the direction is chosen by comparison.
  - motor_sube and motor_baja are never both 1.
  - piso_actual is always exactly one-hot.
- Reset mid-travel: immediate return to the reset values. The car is assumed re-homed to the ground floor.
- Simultaneous mover=1 and puerta=1 in PARADO: no departure and no error; re-evaluate every cycle.

Decomposition:
- Package elevador_pkg contains:
  - the state enum (PARADO, SUBIENDO, BAJANDO, LLEGADA);
  - the default N_FLOORS;
  - an onehot_valid function (exactly one bit set).
- One sub-module: elevador_onehot_cmp. Combinational compare of two one-hot vectors producing mayor, menor and igual; the top level uses it for direction selection.

Test Plan:
- Reset, then release rst → piso_actual=0001, llego=0, motors=0, estado_cab=0, error_cmd=0.
- siguiente=0100, mover=1, puerta=0 (TRAVEL_CYCLES=4):
  - motor_sube=1 for 8 clocks;
  - piso_actual=0010 after 4 clocks, 0100 after 8 clocks;
  - llego=1 on the same edge as the final shift;
  - drop mover → llego=0 next edge, state PARADO.
- From 0100, siguiente=0001:
  - motor_baja for 8 clocks, then llego=1 with piso_actual=0001;
  - change siguiente to 1000 mid-travel → ignored, still stops at 0001.
- Door stall: puerta=1 for 3 clocks, starting 2 clocks into a 0001→0010 travel:
  - motor_sube=0 and counter frozen during the stall;
  - arrival delayed by exactly 3 clocks (llego after 7 clocks instead of 4).
- Invalid and same-floor commands:
  - siguiente=0000 or 0110 with mover=1 → error_cmd=1, no motion;
  - then siguiente equal to piso_actual → error_cmd=0, llego=1 one clock later with no motor activity.
- Reset mid-travel at 0010→1000: rst=0 asynchronously → piso_actual=0001, motors=0, llego=0 immediately, without waiting for a clock edge.
